instruction_fetch: RTL and testbench



---
 rtl/instruction_fetch.sv | 225 ++++++++++++++++++++++
 tb/tb_instruction_fetch.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch.sv
// ============================================================================
// instruction_fetch
// ----------------------------------------------------------------------------
// Fetch stage sitting directly in front of a combinational instruction memory.
// It owns the program counter (a word index) and presents it to the memory.
// It captures the returned word into the IF/ID pipeline register, which feeds
// the decoder.
//
// Control flow:
//   BOOT  : one cycle after reset, no fetch, then RUN.
//   RUN   : priority per edge is redirect > stall > fetch. A PC outside the
//           instruction memory (and no redirect) enters FAULT with a bubble.
//   FAULT : PC held, stall ignored. A redirect loads the PC. An in-range
//           target returns to RUN; the first fetch happens on the next edge.
//
// Ports:
//   clk            in   rising-edge clock
//   rst_n          in   asynchronous active-low reset
//   pc             out  current word index -> instruction memory address
//   instruction    in   combinational read data im[pc]
//   stall          in   hold PC and IF/ID (hazard unit)
//   redirect_en    in   taken branch / jump this cycle
//   redirect_pc    in   word-index redirect target
//   if_id_inst     out  registered instruction for decode
//   if_id_pc       out  word index of if_id_inst
//   if_id_pc_next  out  if_id_pc + 1 (link / branch base)
//   if_id_valid    out  if_id_inst is a real fetched instruction
//   fault          out  PC is outside instruction memory
//   fetch_count    out  instructions delivered to IF/ID (wraps)
// ============================================================================
module instruction_fetch #(
    parameter int               WIDTH     = 32,
    parameter int               MEM_DEPTH = 256,
    parameter logic [WIDTH-1:0] RESET_PC  = '0,
    parameter logic [WIDTH-1:0] NOP_WORD  = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    output logic [WIDTH-1:0] pc,
    input  logic [WIDTH-1:0] instruction,
    input  logic             stall,
    input  logic             redirect_en,
    input  logic [WIDTH-1:0] redirect_pc,
    output logic [WIDTH-1:0] if_id_inst,
    output logic [WIDTH-1:0] if_id_pc,
    output logic [WIDTH-1:0] if_id_pc_next,
    output logic             if_id_valid,
    output logic             fault,
    output logic [WIDTH-1:0] fetch_count
);

    localparam logic [WIDTH-1:0] LP_DEPTH = WIDTH'(MEM_DEPTH);

    typedef enum logic [1:0] {
        S_BOOT  = 2'd0,
        S_RUN   = 2'd1,
        S_FAULT = 2'd2
    } state_t;

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    state_t           r_state;
    logic [WIDTH-1:0] r_pc;
    logic [WIDTH-1:0] r_if_id_inst;
    logic [WIDTH-1:0] r_if_id_pc;
    logic [WIDTH-1:0] r_if_id_pc_next;
    logic             r_if_id_valid;
    logic [WIDTH-1:0] r_fetch_count;

    // ------------------------------------------------------------------------
    // Combinational helpers and control strobes
    // ------------------------------------------------------------------------
    state_t           w_state_next;
    logic [WIDTH-1:0] w_pc_inc;
    logic             w_pc_in_range;
    logic             w_target_in_range;
    logic             w_fetch;      // capture instruction, advance PC
    logic             w_flush;      // load a bubble into IF/ID
    logic             w_pc_load;    // load redirect target into PC
    logic             w_fault;

    // pc+1 wraps modulo 2^WIDTH. A wrapped PC is still caught by the
    // range check before anything is fetched from it.
    assign w_pc_inc          = r_pc + 1'b1;
    assign w_pc_in_range     = (r_pc < LP_DEPTH);
    assign w_target_in_range = (redirect_pc < LP_DEPTH);

    // ------------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_BOOT;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            // BOOT ignores stall and redirect; it only delays the first fetch.
            S_BOOT: begin
                w_state_next = S_RUN;
            end
            // A redirect always wins. Even when the current PC is out of range,
            // the new target is checked on the following cycle.
            S_RUN: begin
                if (!redirect_en && !w_pc_in_range) begin
                    w_state_next = S_FAULT;
                end
            end
            S_FAULT: begin
                if (redirect_en && w_target_in_range) begin
                    w_state_next = S_RUN;
                end
            end
            default: begin
                w_state_next = S_BOOT;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // FSM: output / control decode
    // ------------------------------------------------------------------------
    always_comb begin
        w_fetch   = 1'b0;
        w_flush   = 1'b0;
        w_pc_load = 1'b0;
        w_fault   = 1'b0;
        case (r_state)
            S_BOOT: begin
                // no fetch, no PC movement
            end
            S_RUN: begin
                if (redirect_en) begin
                    // The word at the old PC is on the wrong path: drop it.
                    w_pc_load = 1'b1;
                    w_flush   = 1'b1;
                end else if (!w_pc_in_range) begin
                    // Entering FAULT: nothing valid to hand to decode.
                    w_flush   = 1'b1;
                end else if (!stall) begin
                    w_fetch   = 1'b1;
                end
            end
            S_FAULT: begin
                w_fault = 1'b1;
                // Out-of-range targets are still loaded so software sees
                // where the bad jump went; the FSM stays in FAULT.
                if (redirect_en) begin
                    w_pc_load = 1'b1;
                end
            end
            default: begin
                // unreachable encoding; behave as BOOT
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Program counter
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc <= RESET_PC;
        end else if (w_pc_load) begin
            r_pc <= redirect_pc;
        end else if (w_fetch) begin
            r_pc <= w_pc_inc;
        end
    end

    // ------------------------------------------------------------------------
    // IF/ID pipeline register
    // ------------------------------------------------------------------------
    // A flush only touches inst/valid. if_id_pc and if_id_pc_next keep the
    // last delivered instruction's addresses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_if_id_inst    <= NOP_WORD;
            r_if_id_pc      <= '0;
            r_if_id_pc_next <= '0;
            r_if_id_valid   <= 1'b0;
        end else if (w_fetch) begin
            r_if_id_inst    <= instruction;
            r_if_id_pc      <= r_pc;
            r_if_id_pc_next <= w_pc_inc;
            r_if_id_valid   <= 1'b1;
        end else if (w_flush) begin
            r_if_id_inst    <= NOP_WORD;
            r_if_id_valid   <= 1'b0;
        end
    end

    // ------------------------------------------------------------------------
    // Delivered-instruction counter (wraps naturally at 2^WIDTH)
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fetch_count <= '0;
        end else if (w_fetch) begin
            r_fetch_count <= r_fetch_count + 1'b1;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    // fault is decoded from the state flop, so it is registered in effect
    // and clears on the same edge that returns the FSM to RUN.
    assign pc            = r_pc;
    assign if_id_inst    = r_if_id_inst;
    assign if_id_pc      = r_if_id_pc;
    assign if_id_pc_next = r_if_id_pc_next;
    assign if_id_valid   = r_if_id_valid;
    assign fault         = w_fault;
    assign fetch_count   = r_fetch_count;

endmodule

// File: tb/tb_instruction_fetch.sv
module tb_instruction_fetch;

    logic        clk;
    logic        rst_n;

    // DUT A: MEM_DEPTH = 256
    logic [31:0] pc_a, inst_a, rpc_a, ifi_a, ifpc_a, ifpcn_a, cnt_a;
    logic        stall_a, redir_a, v_a, f_a;
    // DUT B: MEM_DEPTH = 8
    logic [31:0] pc_b, inst_b, rpc_b, ifi_b, ifpc_b, ifpcn_b, cnt_b;
    logic        stall_b, redir_b, v_b, f_b;

    int checks = 0;
    int errors = 0;

    // Memory image: word i holds (i+1)*0x11 -> words 0..3 = 11,22,33,44
    function automatic logic [31:0] memf(input logic [31:0] a);
        return (a + 32'd1) * 32'h11;
    endfunction

    assign inst_a = memf(pc_a);
    assign inst_b = memf(pc_b);

    instruction_fetch #(.WIDTH(32), .MEM_DEPTH(256)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .pc(pc_a), .instruction(inst_a),
        .stall(stall_a), .redirect_en(redir_a), .redirect_pc(rpc_a),
        .if_id_inst(ifi_a), .if_id_pc(ifpc_a), .if_id_pc_next(ifpcn_a),
        .if_id_valid(v_a), .fault(f_a), .fetch_count(cnt_a)
    );

    instruction_fetch #(.WIDTH(32), .MEM_DEPTH(8)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .pc(pc_b), .instruction(inst_b),
        .stall(stall_b), .redirect_en(redir_b), .redirect_pc(rpc_b),
        .if_id_inst(ifi_b), .if_id_pc(ifpc_b), .if_id_pc_next(ifpcn_b),
        .if_id_valid(v_b), .fault(f_b), .fetch_count(cnt_b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic        stall;
        logic        redir;
        logic [31:0] rpc;
        logic [31:0] pc;
        logic [31:0] inst;
        logic [31:0] ifpc;
        logic [31:0] ifpcn;
        logic        v;
        logic        f;
        logic [31:0] cnt;
    } vec_t;

    function automatic vec_t mk(input logic s, input logic r, input logic [31:0] rp,
                                input logic [31:0] p, input logic [31:0] i,
                                input logic [31:0] ip, input logic [31:0] ipn,
                                input logic v, input logic f, input logic [31:0] c);
        vec_t t;
        t.stall = s; t.redir = r; t.rpc = rp; t.pc = p; t.inst = i;
        t.ifpc = ip; t.ifpcn = ipn; t.v = v; t.f = f; t.cnt = c;
        return t;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    vec_t tbl[16];

    initial begin
        // stall redir rpc | pc inst ifpc ifpcn v f cnt
        tbl[0]  = mk(0, 0, 0,      32'h0,   32'h0,    32'h0,  32'h0,   0, 0, 0); // BOOT
        tbl[1]  = mk(0, 0, 0,      32'h1,   32'h11,   32'h0,  32'h1,   1, 0, 1);
        tbl[2]  = mk(0, 0, 0,      32'h2,   32'h22,   32'h1,  32'h2,   1, 0, 2);
        tbl[3]  = mk(1, 0, 0,      32'h2,   32'h22,   32'h1,  32'h2,   1, 0, 2); // stall x3
        tbl[4]  = mk(1, 0, 0,      32'h2,   32'h22,   32'h1,  32'h2,   1, 0, 2);
        tbl[5]  = mk(1, 0, 0,      32'h2,   32'h22,   32'h1,  32'h2,   1, 0, 2);
        tbl[6]  = mk(0, 0, 0,      32'h3,   32'h33,   32'h2,  32'h3,   1, 0, 3);
        tbl[7]  = mk(0, 0, 0,      32'h4,   32'h44,   32'h3,  32'h4,   1, 0, 4);
        tbl[8]  = mk(0, 0, 0,      32'h5,   32'h55,   32'h4,  32'h5,   1, 0, 5);
        tbl[9]  = mk(1, 1, 32'h40, 32'h40,  32'h0,    32'h4,  32'h5,   0, 0, 5); // redirect beats stall
        tbl[10] = mk(0, 0, 0,      32'h41,  32'h451,  32'h40, 32'h41,  1, 0, 6);
        tbl[11] = mk(0, 1, 32'hFF, 32'hFF,  32'h0,    32'h40, 32'h41,  0, 0, 6); // jump to last word
        tbl[12] = mk(0, 0, 0,      32'h100, 32'h1100, 32'hFF, 32'h100, 1, 0, 7); // boundary fetch
        tbl[13] = mk(0, 0, 0,      32'h100, 32'h0,    32'hFF, 32'h100, 0, 1, 7); // enter FAULT
        tbl[14] = mk(0, 1, 32'h2,  32'h2,   32'h0,    32'hFF, 32'h100, 0, 0, 7); // recover
        tbl[15] = mk(0, 0, 0,      32'h3,   32'h33,   32'h2,  32'h3,   1, 0, 8);

        stall_a = 0; redir_a = 0; rpc_a = 0;
        stall_b = 0; redir_b = 0; rpc_b = 0;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #2;
        chk("reset pc", pc_a, 32'h0);
        chk("reset inst", ifi_a, 32'h0);
        chk("reset ifpc", ifpc_a, 32'h0);
        chk("reset ifpcn", ifpcn_a, 32'h0);
        chk("reset valid", {31'b0, v_a}, 32'h0);
        chk("reset fault", {31'b0, f_a}, 32'h0);
        chk("reset count", cnt_a, 32'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        for (int i = 0; i < 16; i++) begin
            stall_a = tbl[i].stall;
            redir_a = tbl[i].redir;
            rpc_a   = tbl[i].rpc;
            step();
            chk($sformatf("row%0d pc", i),    pc_a,    tbl[i].pc);
            chk($sformatf("row%0d inst", i),  ifi_a,   tbl[i].inst);
            chk($sformatf("row%0d ifpc", i),  ifpc_a,  tbl[i].ifpc);
            chk($sformatf("row%0d ifpcn", i), ifpcn_a, tbl[i].ifpcn);
            chk($sformatf("row%0d valid", i), {31'b0, v_a}, {31'b0, tbl[i].v});
            chk($sformatf("row%0d fault", i), {31'b0, f_a}, {31'b0, tbl[i].f});
            chk($sformatf("row%0d count", i), cnt_a,   tbl[i].cnt);
        end
        stall_a = 0; redir_a = 0; rpc_a = 0;

        // Asynchronous reset mid-fetch, away from any clock edge
        step(); step();
        #2 rst_n = 1'b0;
        #1;
        chk("async pc", pc_a, 32'h0);
        chk("async valid", {31'b0, v_a}, 32'h0);
        chk("async count", cnt_a, 32'h0);
        chk("async inst", ifi_a, 32'h0);
        step();
        rst_n = 1'b1;
        step();
        chk("post-reset boot valid", {31'b0, v_a}, 32'h0);
        chk("post-reset boot pc", pc_a, 32'h0);
        step();
        chk("post-reset first inst", ifi_a, 32'h11);
        chk("post-reset first valid", {31'b0, v_a}, 32'h1);
        chk("post-reset count", cnt_a, 32'h1);

        // DUT B: running off the end of an 8-word memory
        rst_n = 1'b0;
        #1;
        chk("b reset pc", pc_b, 32'h0);
        chk("b reset fault", {31'b0, f_b}, 32'h0);
        step();
        rst_n = 1'b1;
        step(); // BOOT
        chk("b boot valid", {31'b0, v_b}, 32'h0);
        for (int k = 0; k < 8; k++) step();
        chk("b word7 inst", ifi_b, 32'h88);
        chk("b word7 ifpc", ifpc_b, 32'h7);
        chk("b word7 valid", {31'b0, v_b}, 32'h1);
        chk("b word7 pc", pc_b, 32'h8);
        chk("b word7 count", cnt_b, 32'h8);
        chk("b word7 fault", {31'b0, f_b}, 32'h0);
        step();
        chk("b fault set", {31'b0, f_b}, 32'h1);
        chk("b fault valid", {31'b0, v_b}, 32'h0);
        chk("b fault pc", pc_b, 32'h8);
        chk("b fault inst", ifi_b, 32'h0);
        for (int k = 0; k < 4; k++) begin
            stall_b = ~stall_b;
            step();
            chk($sformatf("b stall%0d fault", k), {31'b0, f_b}, 32'h1);
            chk($sformatf("b stall%0d pc", k), pc_b, 32'h8);
            chk($sformatf("b stall%0d valid", k), {31'b0, v_b}, 32'h0);
        end
        stall_b = 0;
        redir_b = 1; rpc_b = 32'h100;
        step();
        chk("b bad redirect fault", {31'b0, f_b}, 32'h1);
        chk("b bad redirect pc", pc_b, 32'h100);
        rpc_b = 32'h3;
        step();
        chk("b recover fault", {31'b0, f_b}, 32'h0);
        chk("b recover pc", pc_b, 32'h3);
        chk("b recover valid", {31'b0, v_b}, 32'h0);
        redir_b = 0; rpc_b = 0;
        step();
        chk("b resume inst", ifi_b, 32'h44);
        chk("b resume ifpc", ifpc_b, 32'h3);
        chk("b resume ifpcn", ifpcn_b, 32'h4);
        chk("b resume valid", {31'b0, v_b}, 32'h1);
        chk("b resume count", cnt_b, 32'h9);
        chk("b resume pc", pc_b, 32'h4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
